// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl - load/store control stage in front of the data memory
//
// Takes one load/store request at a time from the EX/MEM pipeline register
// over a valid/ready handshake, checks alignment and opcode, and sequences the
// data memory (two 256x32 SRAM banks, bank = address bit 10). Loads are held
// stable through the SRAM data cycle and the returned word is optionally
// zero-extended (LBU/LHU).
//
// Build option:
//   LSU_RANGE_CHECK_EN  when defined, req_addr[31:ADDR_W] != 0 is an error.
//                       When undefined the upper address bits are ignored and
//                       the address wraps modulo 2^ADDR_W.
//
// Ports:
//   clk, nrst           clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_op              000 SB, 001 SH, 010 SW, 100 LB, 101 LH, 110 LW
//   req_unsigned        zero-extend LB/LH results
//   req_addr, req_wdata byte address, right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_err            error qualifier for resp_valid
//   resp_rdata          load result
//   busy                pipeline stall request (= ~req_ready)
//   mem_stall, mem_op,  memory control: stall (1 = deselected), op_code,
//   mem_addr, mem_wdata byte address and write data
//   mem_rdata           memory read data (lane-extracted, sign-extended)
//
// State table:
//   state    | meaning
//   IDLE     | waiting for a request, memory deselected
//   ACCESS   | SRAM enabled, clocked at the end of this cycle
//   RESP     | load data cycle, address/op held for memory lane mux
//   ERR      | error response being presented
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int          ADDR_W  = 11,
  parameter logic [2:0]  OP_IDLE = 3'b111
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic              mem_stall,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q,   resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_stall_q,  mem_stall_d;
  logic [2:0]        mem_op_q,     mem_op_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [31:0]       mem_wdata_q,  mem_wdata_d;
  logic              uns_q,        uns_d;

  logic        op_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] rdata_ext;

  // ---------------------------------------------------------------------------
  // Request checks
  // ---------------------------------------------------------------------------
  always_comb begin
    op_legal = 1'b0;
    case (req_op)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101, 3'b110: op_legal = 1'b1;
      default:                op_legal = 1'b0;
    endcase
  end

  // op[1:0] encodes the access size for both loads and stores.
  always_comb begin
    misaligned = 1'b0;
    case (req_op[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_RANGE_CHECK_EN
  assign out_of_range = |req_addr[31:ADDR_W];
`else
  // Upper address bits intentionally ignored: the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[31:ADDR_W];
  assign out_of_range   = 1'b0;
`endif

  assign req_err = ~op_legal | misaligned | out_of_range;

  // ---------------------------------------------------------------------------
  // Load result extension. The memory already sign-extends; unsigned loads
  // only need the upper bits cleared.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_ext = mem_rdata;
    if (uns_q) begin
      case (mem_op_q[1:0])
        2'b00:   rdata_ext[31:8]  = 24'h0;
        2'b01:   rdata_ext[31:16] = 16'h0;
        default: rdata_ext        = mem_rdata;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_stall_d  = mem_stall_q;
    mem_op_d     = mem_op_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    uns_d        = uns_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            // Response is registered on entry to ERR, giving latency 1.
            // Memory outputs stay untouched: no SRAM access at all.
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            mem_stall_d = 1'b0;
            mem_op_d    = req_op;
            mem_addr_d  = req_addr[ADDR_W-1:0];
            mem_wdata_d = req_wdata;
            uns_d       = req_unsigned;
          end
        end
      end

      S_ACCESS: begin
        mem_stall_d = 1'b1;
        if (!mem_op_q[2]) begin
          // Store completes once the SRAM has been clocked.
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          mem_op_d     = OP_IDLE;
        end else begin
          // Load: keep addr/op so the memory lane select and bank mux stay
          // valid during the data cycle.
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = rdata_ext;
        mem_op_d     = OP_IDLE;
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mem_stall_d = 1'b1;
        mem_op_d    = OP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_stall_q  <= 1'b1;
      mem_op_q     <= OP_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_stall_q  <= mem_stall_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      uns_q        <= uns_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_stall  = mem_stall_q;
  assign mem_op     = mem_op_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl - directed bench for lsu_ctrl with a small two-bank SRAM model
// (512 words, index = {addr[10], addr[9:2]}, lane-extracted sign-extended
// read data registered on the enabled clock).
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        mem_stall;
  logic [2:0]  mem_op;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  lsu_ctrl #(.ADDR_W(11), .OP_IDLE(3'b111)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .busy         (busy),
    .mem_stall    (mem_stall),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // SRAM model
  // ---------------------------------------------------------------------------
  logic [31:0] sram [0:511];
  logic [31:0] raw_q;

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = 32'h0;
    raw_q = 32'h0;
  end

  always @(posedge clk) begin
    logic [8:0]  idx;
    logic [31:0] w;
    idx = {mem_addr[10], mem_addr[9:2]};
    if (!mem_stall) begin
      if (!mem_op[2]) begin
        w = sram[idx];
        case (mem_op[1:0])
          2'b00:   w[{mem_addr[1:0], 3'b000} +: 8]  = mem_wdata[7:0];
          2'b01:   w[{mem_addr[1], 4'b0000} +: 16] = mem_wdata[15:0];
          default: w = mem_wdata;
        endcase
        sram[idx] <= w;
      end else begin
        raw_q <= sram[idx];
      end
    end
  end

  always_comb begin
    logic [31:0] sh;
    sh        = raw_q >> {mem_addr[1:0], 3'b000};
    mem_rdata = raw_q;
    case (mem_op[1:0])
      2'b00:   mem_rdata = {{24{sh[7]}}, sh[7:0]};
      2'b01:   mem_rdata = {{16{sh[15]}}, sh[15:0]};
      default: mem_rdata = raw_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Issue one request, then watch cycles N+1..N+4 for the response.
  task automatic do_req(input string tag, input logic [2:0] op, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd);
    int          lat;
    int          pulses;
    int          stall_lo;
    logic        err_seen;
    logic [31:0] rd_seen;
    logic [2:0]  op1;
    logic [10:0] addr1;
    lat = 0; pulses = 0; stall_lo = 0; err_seen = 1'b0; rd_seen = 32'h0;
    op1 = 3'b000; addr1 = 11'h0;
    @(negedge clk);
    chk({tag, "/ready"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_op       = op;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        op1   = mem_op;
        addr1 = mem_addr;
      end
      if (!mem_stall) stall_lo++;
      if (resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat      = i;
          err_seen = resp_err;
          rd_seen  = resp_rdata;
        end
      end
    end
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/pulses"}, pulses, 32'd1);
    chk({tag, "/err"}, {31'h0, err_seen}, {31'h0, exp_err});
    chk({tag, "/stall_lo_cycles"}, stall_lo, exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      chk({tag, "/mem_op"}, {29'h0, op1}, {29'h0, op});
      chk({tag, "/mem_addr"}, {21'h0, addr1}, {21'h0, addr[10:0]});
    end
    if (chk_rd) chk({tag, "/rdata"}, rd_seen, exp_rd);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          acc [3];
    int          k;
    int          pulses;
    int          busy_cnt;
    logic [31:0] rd [3];

    nrst = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    chk("rst/ready",      {31'h0, req_ready},  32'h1);
    chk("rst/busy",       {31'h0, busy},       32'h0);
    chk("rst/mem_stall",  {31'h0, mem_stall},  32'h1);
    chk("rst/mem_op",     {29'h0, mem_op},     32'h7);
    chk("rst/mem_addr",   {21'h0, mem_addr},   32'h0);
    chk("rst/resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst/resp_rdata", resp_rdata,          32'h0);
    @(negedge clk);
    nrst = 1'b1;

    // Word store / load round trip
    do_req("sw404", 3'b010, 1'b0, 32'h404, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);
    do_req("lw404", 3'b110, 1'b0, 32'h404, 32'h0,        3, 1'b0, 1'b1, 32'hDEADBEEF);

    // Byte store into an existing word, signed/unsigned byte loads
    do_req("sw004", 3'b010, 1'b0, 32'h004, 32'h11223344, 2, 1'b0, 1'b0, 32'h0);
    do_req("sb006", 3'b000, 1'b0, 32'h006, 32'h000000A5, 2, 1'b0, 1'b0, 32'h0);
    do_req("lb006", 3'b100, 1'b0, 32'h006, 32'h0,        3, 1'b0, 1'b1, 32'hFFFFFFA5);
    do_req("lbu006",3'b100, 1'b1, 32'h006, 32'h0,        3, 1'b0, 1'b1, 32'h000000A5);
    do_req("lw004", 3'b110, 1'b0, 32'h004, 32'h0,        3, 1'b0, 1'b1, 32'h11A53344);

    // Halfword loads, signed and unsigned; unsigned ignored for LW
    do_req("lh406", 3'b101, 1'b0, 32'h406, 32'h0,        3, 1'b0, 1'b1, 32'hFFFFDEAD);
    do_req("lhu406",3'b101, 1'b1, 32'h406, 32'h0,        3, 1'b0, 1'b1, 32'h0000DEAD);
    do_req("lwu404",3'b110, 1'b1, 32'h404, 32'h0,        3, 1'b0, 1'b1, 32'hDEADBEEF);

    // Errors: misaligned and illegal op
    do_req("lh003", 3'b101, 1'b0, 32'h003, 32'h0,        1, 1'b1, 1'b0, 32'h0);
    do_req("lw002", 3'b110, 1'b0, 32'h002, 32'h0,        1, 1'b1, 1'b0, 32'h0);
    do_req("op011", 3'b011, 1'b0, 32'h000, 32'h0,        1, 1'b1, 1'b0, 32'h0);
    do_req("op111", 3'b111, 1'b0, 32'h000, 32'h0,        1, 1'b1, 1'b0, 32'h0);
    do_req("sh001", 3'b001, 1'b0, 32'h001, 32'hFFFF,     1, 1'b1, 1'b0, 32'h0);
    do_req("sw402", 3'b010, 1'b0, 32'h402, 32'h12345678, 1, 1'b1, 1'b0, 32'h0);
    // Failed SW must not have disturbed the word
    do_req("lw404b",3'b110, 1'b0, 32'h404, 32'h0,        3, 1'b0, 1'b1, 32'hDEADBEEF);

    // Back-to-back with req_valid held: LW 404, SW 008, LW 008
    k = 0; pulses = 0; busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin acc[i] = -1; rd[i] = 32'h0; end
    for (int c = 0; c < 12; c++) begin
      if (resp_valid) begin
        if (pulses < 3) rd[pulses] = resp_rdata;
        pulses++;
      end
      if (busy) busy_cnt++;
      if (req_ready) begin
        if (k < 3) begin
          req_valid = 1'b1; req_unsigned = 1'b0; acc[k] = c;
          case (k)
            0:       begin req_op = 3'b110; req_addr = 32'h404; req_wdata = 32'h0; end
            1:       begin req_op = 3'b010; req_addr = 32'h008; req_wdata = 32'hCAFEF00D; end
            default: begin req_op = 3'b110; req_addr = 32'h008; req_wdata = 32'h0; end
          endcase
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b/acc0",   acc[0],   32'd0);
    chk("b2b/acc1",   acc[1],   32'd3);
    chk("b2b/acc2",   acc[2],   32'd5);
    chk("b2b/pulses", pulses,   32'd3);
    chk("b2b/busy",   busy_cnt, 32'd5);
    chk("b2b/rd0",    rd[0],    32'hDEADBEEF);
    chk("b2b/rd2",    rd[2],    32'hCAFEF00D);

    // Upper address bits: error with range check, wrap to word 0 without
    do_req("sw000", 3'b010, 1'b0, 32'h000, 32'h55AA1234, 2, 1'b0, 1'b0, 32'h0);
`ifdef LSU_RANGE_CHECK_EN
    do_req("lw800", 3'b110, 1'b0, 32'h800, 32'h0,        1, 1'b1, 1'b0, 32'h0);
`else
    do_req("lw800", 3'b110, 1'b0, 32'h800, 32'h0,        3, 1'b0, 1'b1, 32'h55AA1234);
`endif

    // Reset while in RESP
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b110; req_unsigned = 1'b0;
    req_addr = 32'h404; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid/in_resp_busy",  {31'h0, busy},      32'h1);
    chk("rstmid/in_resp_stall", {31'h0, mem_stall}, 32'h1);
    #1 nrst = 1'b0;
    #1;
    chk("rstmid/mem_stall",  {31'h0, mem_stall},  32'h1);
    chk("rstmid/mem_op",     {29'h0, mem_op},     32'h7);
    chk("rstmid/resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstmid/mem_addr",   {21'h0, mem_addr},   32'h0);
    @(negedge clk);
    nrst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("rstmid/stale_pulses", pulses, 32'd0);
    chk("rstmid/ready",        {31'h0, req_ready}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
